mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width in bits.
REQ-002 Parameter DATA_W, default 8, memory data width in bits.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0  input  1  port 0 (loader) access request.
REQ-006 we0  input  1  port 0 write enable (1 write, 0 read).
REQ-007 addr0  input  ADDR_W  port 0 address.
REQ-008 wdata0  input  DATA_W  port 0 write data.
REQ-009 ack0  output  1  port 0 access-complete pulse.
REQ-010 rdata0  output  DATA_W  port 0 read data, registered.
REQ-011 req1, we1, addr1, wdata1, ack1, rdata1 SHALL have the same widths and meanings for port 1 (cpu).
REQ-012 mem_en  output  1  memory access strobe.
REQ-013 mem_we  output  1  memory write enable.
REQ-014 mem_addr  output  ADDR_W  memory address.
REQ-015 mem_wdata  output  DATA_W  memory write data.
REQ-016 mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_en.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, CAPTURE, DONE; every access passes through all four in order, then returns to IDLE.
REQ-018 IDLE: no req -> stay IDLE; any req -> latch winner, its we/addr/wdata into registered mem_* outputs, mem_en=1, go ACCESS.
REQ-019 ACCESS: mem_en high for exactly this one cycle; mem_we=latched we; go CAPTURE.
REQ-020 CAPTURE: mem_en=0; on read, winner's rdata register loads mem_rdata at the end of this cycle; on write, rdata unchanged; go DONE.
REQ-021 DONE: winner's ack high for exactly this one cycle, rdata valid; other ack low; go IDLE.
REQ-022 Latency: req sampled high in IDLE at edge N -> ack high in cycle N+3; max throughput one access per 4 cycles.
REQ-023 Requester SHALL hold req/we/addr/wdata stable through its ack cycle; arbiter samples requests only in IDLE.
REQ-024 Changes on req/addr/we/wdata outside IDLE SHALL NOT affect the in-flight access.
REQ-025 Non-winning port's rdata SHALL hold its previous value.
REQ-026 Arbitration on simultaneous req0 and req1 follows REQ-031/REQ-032; a single requester always wins.
REQ-027 Holding req high after ack SHALL be treated as a new request in the following IDLE cycle.

Reset
REQ-028 rst high at an edge SHALL force state IDLE; mem_en, mem_we, ack0, ack1 = 0; mem_addr, mem_wdata, rdata0, rdata1 = 0.
REQ-029 Reset mid-operation SHALL abort the access with no ack; a write whose ACCESS cycle coincides with the reset edge still reaches memory (mem_en already high).
REQ-030 Round-robin pointer SHALL reset to "last granted = port 1", so port 0 wins the first tie.

Configuration
REQ-031 With ARB_RR_EN defined: round robin; on a tie the port not granted most recently wins; pointer updates on each IDLE->ACCESS.
REQ-032 Without ARB_RR_EN: fixed priority, port 0 always wins a tie; no pointer register.

Verification
REQ-033 Reset 2 cycles -> all outputs 0, state IDLE, mem_en never high.
REQ-034 Port 0 write addr=0x00 data=0x01, then 0x01->0x02, 0x02->0x03 -> one mem_en/mem_we pulse each; ack0 4th cycle after each request edge.
REQ-035 Port 1 read addr=0x01, memory model returns 0x02 -> ack1 at N+3 with rdata1=0x02; rdata0 unchanged.
REQ-036 req0 and req1 held high for 4 accesses -> ARB_RR_EN: grants 0,1,0,1; without: 0,0,0,0 with ack1 never asserted.
REQ-037 rst asserted during CAPTURE of a port 1 read -> no ack1, rdata1=0, next request served normally.
REQ-038 addr1 changed 0x01->0x02 during ACCESS -> mem_addr stays 0x01, rdata1 reflects address 0x01.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (loader / cpu) arbiter onto a single synchronous memory port.
// Define ARB_RR_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_q;
    logic              win_q;
    logic              we_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              ack0_q;
    logic              ack1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              win_d;
    logic              any_req;

    assign any_req = req0 | req1;

`ifdef ARB_RR_EN
    // last_q holds the most recently granted port; a tie goes to the other one.
    logic last_q;

    always_comb begin
        if (req0 && req1) begin
            win_d = ~last_q;
        end else begin
            win_d = ~req0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (state_q == IDLE && any_req) begin
            last_q <= win_d;
        end
    end
`else
    always_comb begin
        win_d = ~req0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            win_q       <= 1'b0;
            we_q        <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        // Request is captured here; later input changes are ignored.
                        win_q       <= win_d;
                        we_q        <= win_d ? we1 : we0;
                        mem_we_q    <= win_d ? we1 : we0;
                        mem_addr_q  <= win_d ? addr1 : addr0;
                        mem_wdata_q <= win_d ? wdata1 : wdata0;
                        mem_en_q    <= 1'b1;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    state_q  <= CAPTURE;
                end
                CAPTURE: begin
                    if (!we_q) begin
                        if (win_q) begin
                            rdata1_q <= mem_rdata;
                        end else begin
                            rdata0_q <= mem_rdata;
                        end
                    end
                    ack0_q  <= ~win_q;
                    ack1_q  <= win_q;
                    state_q <= DONE;
                end
                DONE: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed steps plus randomized accesses checked against
// a transaction-level model (expected memory image, arbitration rule, fixed latency).
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, we0, req1, we1;
    logic [7:0] addr0, wdata0, addr1, wdata1;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    bit         ref_last;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .state_dbg(state_dbg)
    );

    // Synchronous memory: data for an mem_en cycle appears the following cycle.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pick(input bit r0, input bit r1);
        if (r0 && r1) begin
`ifdef ARB_RR_EN
            return !ref_last;
`else
            return 1'b0;
`endif
        end
        return r1 && !r0;
    endfunction

    // One access from the IDLE state; optionally scrambles all inputs mid-flight.
    task automatic run_txn(input bit r0, input bit r1, input bit w0, input bit w1,
                           input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] d0, input logic [7:0] d1, input bit perturb);
        bit         w;
        bit         got;
        int         cyc, en_cnt, we_cnt;
        logic [7:0] p0, p1, acc_addr, exp_rd;
        bit         exp_we;
        logic [7:0] exp_a, exp_d;
        @(negedge clk);
        req0 = r0; req1 = r1; we0 = w0; we1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        w      = pick(r0, r1);
        ref_last = w;
        exp_we = w ? w1 : w0;
        exp_a  = w ? a1 : a0;
        exp_d  = w ? d1 : d0;
        p0 = rdata0; p1 = rdata1;
        cyc = 0; en_cnt = 0; we_cnt = 0; got = 0; acc_addr = 8'h00;
        while (cyc < 8 && !got) begin
            @(posedge clk); #1; cyc++;
            if (mem_en) begin
                en_cnt++;
                acc_addr = mem_addr;
            end
            if (mem_we) we_cnt++;
            if (ack0 || ack1) got = 1;
            if (cyc == 1 && perturb) begin
                @(negedge clk);
                addr0 = ~a0; addr1 = ~a1; wdata0 = ~d0; wdata1 = ~d1; we0 = ~w0; we1 = ~w1;
            end
        end
        exp_rd = exp_we ? (w ? p1 : p0) : ref_mem[exp_a];
        if (exp_we) ref_mem[exp_a] = exp_d;
        chk("ack_latency", cyc, 3);
        chk("ack_port1", ack1, w);
        chk("ack_port0", ack0, !w);
        chk("mem_en_pulses", en_cnt, 1);
        chk("mem_we_pulses", we_cnt, exp_we);
        chk("mem_addr", acc_addr, exp_a);
        chk("rdata_winner", w ? rdata1 : rdata0, exp_rd);
        chk("rdata_other", w ? rdata0 : rdata1, w ? p0 : p1);
        @(negedge clk);
        req0 = 0; req1 = 0;
        @(negedge clk);
        if (exp_we) chk("mem_image", mem[exp_a], exp_d);
    endtask

    initial begin
        bit         g_q[$];
        bit         e_q[$];
        bit         r0, r1;
        rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        ref_last = 1;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end

        // Reset for two cycles.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst_mem_en", mem_en, 0);
        end
        chk("rst_state", state_dbg, 0);
        chk("rst_acks", {ack0, ack1, mem_we}, 0);
        chk("rst_bus", {mem_addr, mem_wdata}, 0);
        chk("rst_rdata", {rdata0, rdata1}, 0);
        @(negedge clk);
        rst = 0;

        // Loader writes, then cpu read of address 1.
        run_txn(1, 0, 1, 0, 8'h00, 8'h00, 8'h01, 8'h00, 0);
        run_txn(1, 0, 1, 0, 8'h01, 8'h00, 8'h02, 8'h00, 0);
        run_txn(1, 0, 1, 0, 8'h02, 8'h00, 8'h03, 8'h00, 0);
        run_txn(0, 1, 0, 0, 8'h00, 8'h01, 8'h00, 8'h00, 0);
        chk("cpu_read_0x01", rdata1, 8'h02);

        // Address change during ACCESS must not disturb the access.
        run_txn(0, 1, 0, 0, 8'h00, 8'h01, 8'h00, 8'h00, 1);
        chk("perturbed_read", rdata1, 8'h02);

        // Both ports held high across four accesses.
        @(negedge clk);
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'h03; addr1 = 8'h04;
        for (int i = 0; i < 4; i++) begin
            e_q.push_back(pick(1, 1));
            ref_last = e_q[i];
        end
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (ack0) g_q.push_back(1'b0);
            if (ack1) g_q.push_back(1'b1);
        end
        @(negedge clk);
        req0 = 0; req1 = 0;
        chk("hold_grant_count", g_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("hold_grant_port", (i < g_q.size()) ? 32'(g_q[i]) : 32'hFFFF, e_q[i]);
        end
        @(negedge clk);

        // Reset during CAPTURE of a cpu read.
        req1 = 1; we1 = 0; addr1 = 8'h01;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_capture", state_dbg, 2);
        @(negedge clk);
        rst = 1; req1 = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("abort_no_ack1", ack1, 0);
            chk("abort_rdata1", rdata1, 0);
            chk("abort_state", state_dbg, 0);
        end
        @(negedge clk);
        rst = 0;
        ref_last = 1;
        run_txn(0, 1, 0, 0, 8'h00, 8'h01, 8'h00, 8'h00, 0);
        chk("post_rst_read", rdata1, ref_mem[1]);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1;
            run_txn(r0, r1, 1'($urandom), 1'($urandom),
                    8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                    8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
